// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done handshake bundle for the bit-serial adder
//
// Signals:
//   start    request a new operation (driven by master)
//   a, b     WIDTH-bit operands (driven by master)
//   sub      select a-b (only with SERIAL_SUB_EN defined)
//   sum      registered WIDTH-bit result (driven by slave)
//   cout     registered final carry / no-borrow flag (driven by slave)
//   busy     high while an operation is in flight (driven by slave)
//   done     one-cycle completion pulse (driven by slave)
// Optional feature macro: SERIAL_SUB_EN
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

`ifdef SERIAL_SUB_EN
    modport master (output start, a, b, sub, input sum, cout, busy, done);
    modport slave  (input start, a, b, sub, output sum, cout, busy, done);
`else
    modport master (output start, a, b, input sum, cout, busy, done);
    modport slave  (input start, a, b, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with start/done handshake
//
// One full adder (two half adders plus an OR) and a carry flop are reused
// over WIDTH cycles. Latency from accept to done is WIDTH+1 cycles.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   serial_adder_if.slave: start, a, b, [sub], sum, cout, busy, done
// Optional feature macro: SERIAL_SUB_EN (adds subtraction via bus.sub)
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic p, g1, s, g2, c_next;

    always_comb begin
        // Full adder on the current LSBs: half adder 1, half adder 2, OR.
        p      = a_q[0] ^ b_q[0];
        g1     = a_q[0] & b_q[0];
        s      = p ^ c_q;
        g2     = p & c_q;
        c_next = g1 | g2;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = 1'b0;
`ifdef SERIAL_SUB_EN
                    // a - b computed as a + ~b + 1: the +1 enters as carry-in.
                    if (bus.sub) begin
                        b_d = ~bus.b;
                    end
                    c_d     = bus.sub;
`endif
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                res_d = {s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the completed shift register, not res_q,
                // so sum sees the MSB computed on this same edge.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {s, res_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   done_count;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic [W:0]   expq[$];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bb;
        bb = s ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            logic [W:0] e;
            done_count++;
            if (expq.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                check("sum", 64'(bus.sum), 64'(e[W-1:0]));
                check("cout", 64'(bus.cout), 64'(e[W]));
            end
        end
    end

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.a = a;
        bus.b = b;
`ifdef SERIAL_SUB_EN
        bus.sub = s;
`endif
    endtask

    // Runs one operation; checks sum/cout hold during RUN against the prior result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int inject_at, output int lat, output int busy_cnt);
        logic [W:0] e;
        e = model(a, b, s);
        expq.push_back(e);
        @(negedge clk);
        drive_ops(a, b, s);
        bus.start = 1'b1;
        @(posedge clk);
        lat = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == inject_at) begin
                drive_ops('1, '1, 1'b0);
                bus.start = 1'b1;
            end else if (inject_at > 0 && n == inject_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = n;
                break;
            end
            check("sum_hold", 64'(bus.sum), 64'(prev_sum));
            check("cout_hold", 64'(bus.cout), 64'(prev_cout));
        end
        if (lat == 0) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("busy_after_done", 64'(bus.busy), 64'd0);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        prev_sum  = e[W-1:0];
        prev_cout = e[W];
    endtask

    initial begin
        int lat, bc, dc0, nd, last;
        n_pass = 0;
        n_total = 0;
        done_count = 0;
        prev_sum = '0;
        prev_cout = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        drive_ops('0, '0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h35, 8'h4A, 1'b0, 0, lat, bc);
        check("latency", 64'(lat), 64'(W + 1));
        check("busy_cycles", 64'(bc), 64'(W + 1));

        run_op(8'hFF, 8'h01, 1'b0, 0, lat, bc);
        run_op(8'h80, 8'h80, 1'b0, 0, lat, bc);
        check("latency_2", 64'(lat), 64'(W + 1));

        dc0 = done_count;
        run_op(8'h12, 8'h34, 1'b0, 3, lat, bc);
        repeat (4) @(negedge clk);
        check("ignored_start_dones", 64'(done_count - dc0), 64'd1);
        check("ignored_start_idle", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the fourth RUN cycle.
        @(negedge clk);
        drive_ops(8'h55, 8'hAA, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_sum", 64'(bus.sum), 64'd0);
        check("arst_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_sum = '0;
        prev_cout = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, 0, lat, bc);
        check("post_rst_latency", 64'(lat), 64'(W + 1));

`ifdef SERIAL_SUB_EN
        run_op(8'h10, 8'h03, 1'b1, 0, lat, bc);
        run_op(8'h03, 8'h10, 1'b1, 0, lat, bc);
        run_op(8'hA5, 8'h3C, 1'b0, 0, lat, bc);
`endif

        // start held high: one result every W+2 cycles.
        for (int i = 0; i < 3; i++) expq.push_back(model(8'hC3, 8'h5A, 1'b0));
        @(negedge clk);
        drive_ops(8'hC3, 8'h5A, 1'b0);
        bus.start = 1'b1;
        nd = 0;
        last = 0;
        for (int n = 0; n < 80 && nd < 3; n++) begin
            @(negedge clk);
            if (bus.done) begin
                if (nd > 0) check("held_period", 64'(n - last), 64'(W + 2));
                last = n;
                nd++;
            end
        end
        bus.start = 1'b0;
        check("held_dones", 64'(nd), 64'd3);
        repeat (W + 4) @(negedge clk);
        check("held_no_extra", 64'(bus.busy), 64'd0);
        check("scoreboard_empty", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
